// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the fetch queue: PC stride, decode-stage
// PC offset and the width of the occupancy counter.
package fetch_queue_pkg;
    localparam int PC_INC     = 4;
    localparam int DECODE_OFF = 8;

    // Counter must represent 0..DEPTH inclusive, hence the extra bit.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fq_ring.sv
// Ring buffer of {pc, instr} entries with head/tail pointers and occupancy.
// The head entry is read combinationally so decode sees it the cycle after the write.
module fq_ring
    import fetch_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        clear_i,
    input  logic [ADDR_W-1:0]           wr_pc_i,
    input  logic [DATA_W-1:0]           wr_instr_i,
    output logic                        head_valid_o,
    output logic [ADDR_W-1:0]           head_pc_o,
    output logic [DATA_W-1:0]           head_instr_o,
    output logic [count_w(DEPTH)-1:0]   count_o,
    output logic                        full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            pc_mem[tail_q]    <= wr_pc_i;
            instr_mem[tail_q] <= wr_instr_i;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PW'(1);
            if (pop_i)  head_d = head_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign full_o       = (count_q == CW'(DEPTH));
    assign count_o      = count_q;
    assign head_pc_o    = pc_mem[head_q];
    assign head_instr_o = instr_mem[head_q];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC and redirect handling, and buffers
// fetched words for decode in an fq_ring.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [ADDR_W-1:0]           PCF,
    output logic                        FetchEnF,
    input  logic [DATA_W-1:0]           InstrF,
    input  logic                        Flush,
    input  logic [ADDR_W-1:0]           BranchTarget,
    input  logic                        StallD,
    output logic                        ValidD,
    output logic [DATA_W-1:0]           InstrD,
    output logic [ADDR_W-1:0]           PCPlus8D,
    output logic [count_w(DEPTH)-1:0]   Count
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              push, pop;
    logic              head_valid, full;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;

    // A full queue may still accept a word when the head leaves in the same cycle.
    assign pop  = head_valid && !StallD && !Flush;
    assign push = !Flush && (!full || pop);

    always_comb begin
        pc_d = pc_q;
        if (Flush)     pc_d = BranchTarget;
        else if (push) pc_d = pc_q + ADDR_W'(PC_INC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    fq_ring #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk          (clk),
        .rst          (reset),
        .push_i       (push),
        .pop_i        (pop),
        .clear_i      (Flush),
        .wr_pc_i      (pc_q),
        .wr_instr_i   (InstrF),
        .head_valid_o (head_valid),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .count_o      (Count),
        .full_o       (full)
    );

    assign PCF      = pc_q;
    assign FetchEnF = push;
    assign ValidD   = head_valid;
    assign InstrD   = head_valid ? head_instr : '0;
    assign PCPlus8D = head_valid ? (head_pc + ADDR_W'(DECODE_OFF)) : '0;
endmodule
